// File: rtl/stream_rate_limit.sv
// stream_rate_limit: single-register stream stage that lets at most MaxBeats
// transfers through in each window of WindowCycles cycles. Setting limit_en_i
// low bypasses the budget check. The budget still reloads at every window wrap.
// Optional build macro STREAM_RATE_LIMIT_STATS_EN adds stall_cnt_o. This port
// counts the cycles in which upstream was held off by an exhausted budget.
module stream_rate_limit #(
    parameter int Width        = 8,
    parameter int MaxBeats     = 4,
    parameter int WindowCycles = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             limit_en_i,
    input  logic [Width-1:0] payload_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [Width-1:0] payload_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [7:0]       budget_o
`ifdef STREAM_RATE_LIMIT_STATS_EN
    ,
    output logic [15:0]      stall_cnt_o
`endif
);

    typedef enum logic {
        OPEN,
        BLOCKED
    } state_e;

    localparam logic [15:0] WinLast   = 16'(WindowCycles - 1);
    localparam logic [7:0]  BudgetMax = 8'(MaxBeats);

    state_e           state_q, state_d;
    logic [7:0]       budget_q, budget_d;
    logic [15:0]      win_q;
    logic             out_valid_q;
    logic [Width-1:0] out_data_q;
    logic             slot_free;
    logic             accept;
    logic             wrap;

    // The output slot can take a new beat when it is empty or draining this cycle.
    // Reset forces ready low so that nothing is accepted while rst_i is held.
    always_comb begin
        slot_free = ~out_valid_q | ready_i;
        ready_o   = ~rst_i & slot_free & (~limit_en_i | (state_q == OPEN));
        accept    = valid_i & ready_o;
        wrap      = (win_q == WinLast);
    end

    assign valid_o   = out_valid_q;
    assign payload_o = out_data_q;
    assign budget_o  = budget_q;

    // Output register: load on accept, clear once drained with no replacement.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= payload_i;
        end else if (out_valid_q & ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // Free-running window counter, independent of traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q <= '0;
        end else if (wrap) begin
            win_q <= '0;
        end else begin
            win_q <= win_q + 16'd1;
        end
    end

    // Budget and FSM next state.
    // The wrap reload wins over a same-cycle charge, so that beat counts against the old window.
    always_comb begin
        state_d  = state_q;
        budget_d = budget_q;
        if (wrap) begin
            budget_d = BudgetMax;
            state_d  = OPEN;
        end else if (accept && limit_en_i && (state_q == OPEN) && (budget_q != 8'd0)) begin
            budget_d = budget_q - 8'd1;
            if (budget_q == 8'd1) begin
                state_d = BLOCKED;
            end
        end
    end

    // Budget and FSM state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= OPEN;
            budget_q <= BudgetMax;
        end else begin
            state_q  <= state_d;
            budget_q <= budget_d;
        end
    end

`ifdef STREAM_RATE_LIMIT_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles where upstream offered data but the budget was spent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (valid_i && limit_en_i && (state_q == BLOCKED) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stream_rate_limit.sv
// tb_stream_rate_limit: directed self-checking bench for stream_rate_limit.
// It uses the default parameters: Width=8, MaxBeats=4 and WindowCycles=16.
// Inputs change on the falling edge, and outputs are sampled 1 ns after that.
module tb_stream_rate_limit;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       limit_en_i;
    logic [7:0] payload_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] payload_o;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] budget_o;
`ifdef STREAM_RATE_LIMIT_STATS_EN
    logic [15:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    stream_rate_limit dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .limit_en_i (limit_en_i),
        .payload_i  (payload_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .payload_o  (payload_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .budget_o   (budget_o)
`ifdef STREAM_RATE_LIMIT_STATS_EN
        ,
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    // 10 ns clock with rising edges at 5, 15, 25 ns and so on.
    always #5 clk_i = ~clk_i;

    // Count one comparison and report it if the value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle's inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rdy, input logic en);
        valid_i    = v;
        payload_i  = d;
        ready_i    = rdy;
        limit_en_i = en;
        #1;
    endtask

    // Move to the next falling edge, passing through one rising edge.
    task automatic nextCycle();
        @(negedge clk_i);
    endtask

    // Hold reset for two edges and check that ready is forced low meanwhile.
    // On return the bench is in cycle 0 of a fresh window.
    task automatic resetDut();
        @(negedge clk_i);
        rst_i = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
        checkOutput("rst_ready_low", 32'(ready_o), 32'd0);
        nextCycle();
        nextCycle();
        rst_i = 1'b0;
    endtask

    initial begin
        int  accepted;
        int  outBeats;
        logic expValid;
        rst_i      = 1'b1;
        valid_i    = 1'b0;
        payload_i  = 8'h00;
        ready_i    = 1'b0;
        limit_en_i = 1'b1;

        // Reset state.
        resetDut();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("reset_valid", 32'(valid_o), 32'd0);
        checkOutput("reset_payload", 32'(payload_o), 32'd0);
        checkOutput("reset_budget", 32'(budget_o), 32'd4);
        checkOutput("reset_ready", 32'(ready_o), 32'd1);

        // Test 1: full-rate burst with 4 beats per 16-cycle window.
        $display("[TB] Test 1: full-rate burst");
        resetDut();
        accepted = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 8'(c), 1'b1, 1'b1);
            checkOutput($sformatf("t1_ready_c%0d", c), 32'(ready_o), 32'(((c % 16) < 4) ? 1 : 0));
            checkOutput($sformatf("t1_budget_c%0d", c), 32'(budget_o),
                        32'((c < 4) ? 4 - c : (c < 16) ? 0 : 4 - (c - 16)));
            expValid = (c >= 1) && (((c - 1) % 16) < 4);
            checkOutput($sformatf("t1_valid_c%0d", c), 32'(valid_o), 32'(expValid));
            if (expValid) begin
                checkOutput($sformatf("t1_payload_c%0d", c), 32'(payload_o), 32'(c - 1));
            end
`ifdef STREAM_RATE_LIMIT_STATS_EN
            if (c == 16) begin
                checkOutput("t6_stall_cnt", 32'(stall_cnt_o), 32'd12);
            end
`endif
            if (valid_i && ready_o) begin
                accepted++;
            end
            nextCycle();
        end
        checkOutput("t1_accepted", 32'(accepted), 32'd8);

        // Test 2: backpressure holds the beat and the budget.
        $display("[TB] Test 2: backpressure");
        resetDut();
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1);
        checkOutput("t2_accept_ready", 32'(ready_o), 32'd1);
        nextCycle();
        for (int c = 1; c < 4; c++) begin
            applyStimulus((c == 1) ? 1'b0 : 1'b1, 8'h5A, 1'b0, 1'b1);
            checkOutput($sformatf("t2_valid_c%0d", c), 32'(valid_o), 32'd1);
            checkOutput($sformatf("t2_payload_c%0d", c), 32'(payload_o), 32'hA5);
            checkOutput($sformatf("t2_ready_c%0d", c), 32'(ready_o), 32'd0);
            checkOutput($sformatf("t2_budget_c%0d", c), 32'(budget_o), 32'd3);
            nextCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("t2_release_valid", 32'(valid_o), 32'd1);
        checkOutput("t2_release_payload", 32'(payload_o), 32'hA5);
        checkOutput("t2_release_ready", 32'(ready_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("t2_drained_valid", 32'(valid_o), 32'd0);
        checkOutput("t2_drained_budget", 32'(budget_o), 32'd3);

        // Test 3: the last budgeted beat lands on the wrap cycle.
        $display("[TB] Test 3: accept on wrap");
        resetDut();
        outBeats = 0;
        for (int c = 0; c < 18; c++) begin
            applyStimulus((c >= 12 && c <= 15) ? 1'b1 : 1'b0, 8'(8'h10 + c), 1'b1, 1'b1);
            if (c == 15) begin
                checkOutput("t3_budget_c15", 32'(budget_o), 32'd1);
                checkOutput("t3_ready_c15", 32'(ready_o), 32'd1);
            end
            if (c == 16) begin
                checkOutput("t3_budget_c16", 32'(budget_o), 32'd4);
                checkOutput("t3_ready_c16", 32'(ready_o), 32'd1);
            end
            if (valid_o && ready_i) begin
                checkOutput($sformatf("t3_payload_beat%0d", outBeats), 32'(payload_o), 32'(8'h1C + outBeats));
                outBeats++;
            end
            nextCycle();
        end
        checkOutput("t3_out_beats", 32'(outBeats), 32'd4);

        // Test 4: bypass lets 40 back-to-back beats through with the budget untouched.
        $display("[TB] Test 4: bypass");
        resetDut();
        accepted = 0;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b1, 8'(c), 1'b1, 1'b0);
            checkOutput($sformatf("t4_ready_c%0d", c), 32'(ready_o), 32'd1);
            checkOutput($sformatf("t4_budget_c%0d", c), 32'(budget_o), 32'd4);
            if (valid_i && ready_o) begin
                accepted++;
            end
            nextCycle();
        end
        checkOutput("t4_accepted", 32'(accepted), 32'd40);

        // Test 5: reset while a beat is held discards it.
        $display("[TB] Test 5: reset mid-transfer");
        resetDut();
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t5_held_valid", 32'(valid_o), 32'd1);
        checkOutput("t5_held_budget", 32'(budget_o), 32'd3);
        rst_i = 1'b1;
        #1;
        checkOutput("t5_rst_ready", 32'(ready_o), 32'd0);
        nextCycle();
        rst_i = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t5_valid_cleared", 32'(valid_o), 32'd0);
        checkOutput("t5_budget_reload", 32'(budget_o), 32'd4);
        checkOutput("t5_win_cleared", 32'(dut.win_q), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_rate_limit.md
STREAM_RATE_LIMIT -- requirements
Module: stream_rate_limit

Interface
REQ-001 SHALL provide parameter Width, default 8: payload width in bits, at least 1.
REQ-002 SHALL provide parameter MaxBeats, default 4: transfers allowed per window, 1..255.
REQ-003 SHALL provide parameter WindowCycles, default 16: window length in cycles, at least MaxBeats and at most 65535.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL provide port clk_i, input, 1 bit: clock, rising edge.
REQ-006 SHALL provide port rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL provide port limit_en_i, input, 1 bit: 1 enforces the budget, 0 bypasses the budget check.
REQ-008 SHALL provide port payload_i, input, Width bits: upstream data.
REQ-009 SHALL provide port valid_i, input, 1 bit: upstream valid.
REQ-010 SHALL provide port ready_o, output, 1 bit: upstream ready.
REQ-011 SHALL provide port payload_o, output, Width bits: registered data.
REQ-012 SHALL provide port valid_o, output, 1 bit: downstream valid.
REQ-013 SHALL provide port ready_i, input, 1 bit: downstream ready.
REQ-014 SHALL provide port budget_o, output, 8 bits: transfers remaining in the current window.

Function
REQ-015 SHALL hold an output register (out_valid_q, out_data_q) driving valid_o and payload_o directly; this gives 1-cycle latency from input handshake to valid_o.
REQ-016 SHALL compute slot_free = ~out_valid_q | ready_i.
REQ-017 SHALL compute ready_o = slot_free & (~limit_en_i | state == OPEN); ready_o SHALL NOT depend on valid_i.
REQ-018 SHALL accept a beat when valid_i & ready_o, loading out_data_q and setting out_valid_q in the same edge.
REQ-019 SHALL clear out_valid_q when valid_o & ready_i and no beat is accepted that cycle.
REQ-020 SHALL hold payload_o stable while valid_o=1 and ready_i=0.
REQ-021 SHALL run the window counter win_q from 0 to WindowCycles-1, then wrap to 0, free-running regardless of traffic.
REQ-022 SHALL run a 2-state FSM with states OPEN and BLOCKED.
REQ-023 In OPEN, each accepted beat SHALL decrement budget_q when limit_en_i=1; if budget_q==1 at that accept, next state SHALL be BLOCKED.
REQ-024 In BLOCKED, state SHALL stay BLOCKED until the wrap cycle.
REQ-025 On the wrap cycle (win_q==WindowCycles-1), budget_q SHALL reload to MaxBeats and state SHALL become OPEN; the reload overrides a simultaneous decrement, and a beat accepted on the wrap cycle is charged to the ending window.
REQ-026 With limit_en_i=0, budget_q SHALL not decrement; it SHALL still reload on wrap.
REQ-027 budget_o SHALL equal budget_q; budget_q SHALL never underflow below 0.
REQ-028 SHALL not drop a held output beat when limit_en_i changes mid-window.

Reset
REQ-029 SHALL, while rst_i=1 at a clock edge, set out_valid_q=0, out_data_q=0, win_q=0, budget_q=MaxBeats, state=OPEN, and any stats counters to 0.
REQ-030 Reset applied mid-transfer SHALL discard the held beat: valid_o=0 from the next cycle.
REQ-031 While rst_i=1, ready_o SHALL be driven to 0.

Configuration
REQ-032 When macro STREAM_RATE_LIMIT_STATS_EN is defined, SHALL add output port stall_cnt_o, 16 bits, counting cycles with valid_i=1 and state==BLOCKED and limit_en_i=1. The count saturates at 0xFFFF and resets to 0.
REQ-033 When STREAM_RATE_LIMIT_STATS_EN is undefined, port stall_cnt_o and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Test 1 (full-rate burst): defaults, limit_en_i=1, valid_i=1 continuously, ready_i=1 -> exactly 4 beats accepted in cycles 0-3, ready_o=0 in cycles 4-15, and 4 more beats accepted starting cycle 16.
REQ-035 Test 2 (backpressure): ready_i=0 after one accepted beat 0xA5 -> valid_o=1 and payload_o=0xA5 held stable; ready_o=0 and budget_o=3 hold until ready_i=1.
REQ-036 Test 3 (accept on wrap): accept the last budgeted beat on cycle 15 -> budget_o=4 and state OPEN on cycle 16, with no lost or duplicated beat.
REQ-037 Test 4 (bypass): limit_en_i=0 with a 40-beat stream at ready_i=1 -> 40 beats in 40 consecutive cycles, and budget_o stays 4.
REQ-038 Test 5 (reset mid-transfer): rst_i=1 for 1 cycle while valid_o=1 -> valid_o=0, budget_o=4 and win_q=0 on the following cycle.
REQ-039 Test 6 (stats, STREAM_RATE_LIMIT_STATS_EN defined): the Test 1 stimulus -> stall_cnt_o=12 after the first window.
